// File: rtl/restoring_div_ctrl_if.sv
// Handshake and result bundle for the restoring divider controller.
// master drives the operands and start; slave returns status and results.
interface restoring_div_ctrl_if #(
  parameter int WIDTH = 5
);
  logic             start;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_r;
  logic             div_zero;

  modport master (
    output start, in_a, in_b,
    input  busy, done, out_q, out_r, div_zero
  );

  modport slave (
    input  start, in_a, in_b,
    output busy, done, out_q, out_r, div_zero
  );
endinterface

// File: rtl/restoring_div_ctrl.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// state | meaning
// IDLE  | waiting for start; results of the last operation held
// RUN   | one restoring step per edge, WIDTH steps in total
// DONE  | one-cycle done pulse, then back to IDLE unconditionally
module restoring_div_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  restoring_div_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH-1:0] step_diff;
  logic [WIDTH-1:0] step_rem;
  logic             carry;

  // Ripple add of the complemented divisor; the final carry is "no borrow".
  always_comb begin
    trial     = {rem_q, dvd_q[WIDTH-1]};
    sub_b     = ~{1'b0, dvs_q};
    carry     = 1'b1;
    step_diff = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      if (i < WIDTH) step_diff[i] = trial[i] ^ sub_b[i] ^ carry;
      carry = (trial[i] & sub_b[i]) | (carry & (trial[i] ^ sub_b[i]));
    end
    step_rem = carry ? step_diff : trial[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd_q <= bus.in_a;
            dvs_q <= bus.in_b;
            cnt_q <= '0;
            if (bus.in_b == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
              dz_q   <= 1'b1;
              quo_q  <= '1;
              rem_q  <= bus.in_a;
            end else begin
              state  <= RUN;
              busy_q <= 1'b1;
              dz_q   <= 1'b0;
              quo_q  <= '0;
              rem_q  <= '0;
            end
          end
        end
        RUN: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[WIDTH-2:0], carry};
          dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.out_q    = quo_q;
  assign bus.out_r    = rem_q;
  assign bus.div_zero = dz_q;
endmodule
